key_event_multi: RTL

- Multi-channel successor to the single-key debounce/press detector.
- Debounces NUM_KEYS independent active-low buttons and classifies each gesture as short, long, double-click or auto-repeat while held.
- Produces one-cycle event pulses per channel for the UI/control FSMs.
- All channels share a 1 ms tick prescaler, so per-channel counters stay small.

---
 rtl/key_event_multi.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/key_event_multi.sv
// key_event_multi: multi-channel debounced key gesture classifier.
// Each active-low raw key is synchronised, debounced on a shared 1 ms tick,
// then classified as short press, long press, double click or auto-repeat.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   key_in     - raw keys, active low, asynchronous   [NUM_KEYS]
//   key_level  - debounced level, 1 = pressed         [NUM_KEYS]
//   key_short  - short-press pulse, one cycle         [NUM_KEYS]
//   key_long   - long-press pulse, one cycle          [NUM_KEYS]
//   key_double - double-click pulse, one cycle        [NUM_KEYS]
//   key_repeat - auto-repeat pulse, one cycle         [NUM_KEYS]
//   any_event  - OR of all pulse buses, same cycle as the pulses
module key_event_multi #(
    parameter int unsigned NUM_KEYS    = 4,
    parameter int unsigned CLK_FREQ    = 20_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 600,
    parameter int unsigned DCLICK_MS   = 250,
    parameter int unsigned REPEAT_MS   = 100,
    parameter int unsigned REPEAT_EN   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_short,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_double,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_event
);

    localparam int unsigned PRESC_MAX = CLK_FREQ / 1000 - 1;
    localparam int unsigned PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int unsigned DB_W      = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
    localparam int unsigned EV_MAX_LD = (LONG_MS > DCLICK_MS) ? LONG_MS : DCLICK_MS;
    localparam int unsigned EV_MAX    = (EV_MAX_LD > REPEAT_MS) ? EV_MAX_LD : REPEAT_MS;
    localparam int unsigned EV_W      = (EV_MAX > 0) ? $clog2(EV_MAX + 1) : 1;

    // Terminal values: the counter sits at MS-1 on the tick where it reaches MS.
    localparam int unsigned DB_LAST     = (DEBOUNCE_MS > 0) ? DEBOUNCE_MS - 1 : 0;
    localparam int unsigned LONG_LAST   = (LONG_MS > 0) ? LONG_MS - 1 : 0;
    localparam int unsigned DCLICK_LAST = (DCLICK_MS > 0) ? DCLICK_MS - 1 : 0;
    localparam int unsigned REPEAT_LAST = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
    localparam bit          DCLICK_ON   = (DCLICK_MS != 0);
    localparam bit          REPEAT_ON   = (REPEAT_EN != 0);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS  = 3'd1;
    localparam logic [2:0] ST_HOLD   = 3'd2;
    localparam logic [2:0] ST_WAIT2  = 3'd3;
    localparam logic [2:0] ST_PRESS2 = 3'd4;

    logic [PRESC_W-1:0]               presc_q, presc_d;
    logic                             tick_c;
    logic [NUM_KEYS-1:0]              sync0_q, sync1_q;
    logic [NUM_KEYS-1:0]              raw_pressed_c;
    logic [NUM_KEYS-1:0]              level_q, level_d;
    logic [NUM_KEYS-1:0]              level_prev_q;
    logic [NUM_KEYS-1:0]              rise_c;
    logic [NUM_KEYS-1:0][DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [NUM_KEYS-1:0][2:0]         state_q, state_d;
    logic [NUM_KEYS-1:0][EV_W-1:0]    ev_cnt_q, ev_cnt_d;
    logic [NUM_KEYS-1:0]              short_q, short_d;
    logic [NUM_KEYS-1:0]              long_q, long_d;
    logic [NUM_KEYS-1:0]              double_q, double_d;
    logic [NUM_KEYS-1:0]              repeat_q, repeat_d;
    logic                             any_q, any_d;

    assign tick_c        = (presc_q == PRESC_W'(PRESC_MAX));
    assign raw_pressed_c = ~sync1_q;
    // Gesture FSM reacts to edges of the registered debounced level.
    assign rise_c        = level_q & ~level_prev_q;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            sync0_q      <= '1;
            sync1_q      <= '1;
            level_q      <= '0;
            level_prev_q <= '0;
            db_cnt_q     <= '0;
            state_q      <= {NUM_KEYS{ST_IDLE}};
            ev_cnt_q     <= '0;
            short_q      <= '0;
            long_q       <= '0;
            double_q     <= '0;
            repeat_q     <= '0;
            any_q        <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sync0_q      <= key_in;
            sync1_q      <= sync0_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            ev_cnt_q     <= ev_cnt_d;
            short_q      <= short_d;
            long_q       <= long_d;
            double_q     <= double_d;
            repeat_q     <= repeat_d;
            any_q        <= any_d;
        end
    end

    // Prescaler, per-channel debounce and gesture FSM next-state logic
    always_comb begin
        presc_d  = tick_c ? '0 : presc_q + PRESC_W'(1);
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        state_d  = state_q;
        ev_cnt_d = ev_cnt_q;
        short_d  = '0;
        long_d   = '0;
        double_d = '0;
        repeat_d = '0;

        for (int k = 0; k < NUM_KEYS; k++) begin
            // Debounce: count ticks of disagreement, toggle after DEBOUNCE_MS of them.
            if (raw_pressed_c[k] == level_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (tick_c) begin
                if (db_cnt_q[k] == DB_W'(DB_LAST)) begin
                    level_d[k]  = ~level_q[k];
                    db_cnt_d[k] = '0;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end

            case (state_q[k])
                ST_IDLE: begin
                    if (rise_c[k]) begin
                        state_d[k]  = ST_PRESS;
                        ev_cnt_d[k] = '0;
                    end
                end
                ST_PRESS: begin
                    if (!level_q[k]) begin
                        ev_cnt_d[k] = '0;
                        if (DCLICK_ON) begin
                            state_d[k] = ST_WAIT2;
                        end else begin
                            short_d[k] = 1'b1;
                            state_d[k] = ST_IDLE;
                        end
                    end else if (tick_c) begin
                        if (ev_cnt_q[k] == EV_W'(LONG_LAST)) begin
                            long_d[k]   = 1'b1;
                            state_d[k]  = ST_HOLD;
                            ev_cnt_d[k] = '0;
                        end else begin
                            ev_cnt_d[k] = ev_cnt_q[k] + EV_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (!level_q[k]) begin
                        state_d[k] = ST_IDLE;
                    end else if (tick_c) begin
                        if (ev_cnt_q[k] == EV_W'(REPEAT_LAST)) begin
                            repeat_d[k] = REPEAT_ON;
                            ev_cnt_d[k] = '0;
                        end else begin
                            ev_cnt_d[k] = ev_cnt_q[k] + EV_W'(1);
                        end
                    end
                end
                ST_WAIT2: begin
                    // Window expiry beats a coincident second press.
                    if (tick_c && (ev_cnt_q[k] == EV_W'(DCLICK_LAST))) begin
                        short_d[k] = 1'b1;
                        state_d[k] = ST_IDLE;
                    end else if (rise_c[k]) begin
                        state_d[k]  = ST_PRESS2;
                        ev_cnt_d[k] = '0;
                    end else if (tick_c) begin
                        ev_cnt_d[k] = ev_cnt_q[k] + EV_W'(1);
                    end
                end
                ST_PRESS2: begin
                    if (!level_q[k]) begin
                        double_d[k] = 1'b1;
                        state_d[k]  = ST_IDLE;
                    end else if (tick_c) begin
                        if (ev_cnt_q[k] == EV_W'(LONG_LAST)) begin
                            long_d[k]   = 1'b1;
                            state_d[k]  = ST_HOLD;
                            ev_cnt_d[k] = '0;
                        end else begin
                            ev_cnt_d[k] = ev_cnt_q[k] + EV_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[k]  = ST_IDLE;
                    ev_cnt_d[k] = '0;
                end
            endcase
        end

        any_d = |{short_d, long_d, double_d, repeat_d};
    end

    assign key_level  = level_q;
    assign key_short  = short_q;
    assign key_long   = long_q;
    assign key_double = double_q;
    assign key_repeat = repeat_q;
    assign any_event  = any_q;

endmodule
